// File: rtl/decode_issue_stage.sv
// Decode/issue stage: input FIFO, opcode decode, register/flags scoreboard, 1 op/cycle issue.
// Optional DECODE_WB_BYPASS_EN: same-cycle writeback clears count for the hazard check.
module decode_issue_stage #(
    parameter int PC_W     = 64,
    parameter int LANES    = 8,
    parameter int NUM_REGS = 16,
    parameter int DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PC_W-1:0]               in_pc,
    input  logic [31:0]                   in_insn,
    input  logic [LANES-1:0]              in_exec_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PC_W-1:0]               out_pc,
    output logic [LANES-1:0]              out_exec_mask,
    output logic [4:0]                    out_op,
    output logic [$clog2(NUM_REGS)-1:0]   out_dst,
    output logic [$clog2(NUM_REGS)-1:0]   out_src1,
    output logic [$clog2(NUM_REGS)-1:0]   out_src2,
    output logic [63:0]                   out_imm,
    input  logic                          wb_valid,
    input  logic [$clog2(NUM_REGS+1)-1:0] wb_reg,
    input  logic                          flush,
    output logic                          halted,
    output logic                          illegal
);
    localparam int RW  = $clog2(NUM_REGS);
    localparam int SW  = $clog2(NUM_REGS + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int SBN = NUM_REGS + 1;
    localparam logic [SW-1:0] FLAGS = SW'(NUM_REGS);

    localparam logic [4:0] OP_MOVE  = 5'd1;
    localparam logic [4:0] OP_ADD   = 5'd2;
    localparam logic [4:0] OP_ADDI  = 5'd3;
    localparam logic [4:0] OP_CMP   = 5'd4;
    localparam logic [4:0] OP_JMP   = 5'd5;
    localparam logic [4:0] OP_JCC   = 5'd6;
    localparam logic [4:0] OP_STORE = 5'd7;
    localparam logic [4:0] OP_LOAD  = 5'd8;
    localparam logic [4:0] OP_HALT  = 5'd9;

    typedef enum logic [2:0] {
        S_EMPTY, S_DECODE, S_HAZARD, S_ISSUE, S_HALTED
    } state_e;

    state_e state_q, state_d;

    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [31:0]      insn_mem [DEPTH];
    logic [LANES-1:0] mask_mem [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             fifo_empty, fifo_full, push, pop, load, take;

    logic [SBN-1:0] sb_q, sb_d, wb_mask, busy;
    logic           ov_q, ov_d, halted_q, halted_d, illegal_q, illegal_d;

    logic [PC_W-1:0]  pc_q;
    logic [LANES-1:0] mask_q;
    logic [4:0]       op_q;
    logic [RW-1:0]    dst_q, src1_q, src2_q;
    logic [63:0]      imm_q;

    logic [31:0]   h_insn;
    logic [7:0]    h_opc, fa, fb, fc;
    logic [4:0]    d_op;
    logic [RW-1:0] d_dst, d_src1, d_src2;
    logic [63:0]   d_imm;
    logic          u_dst, u_s1, u_s2, r_fl, w_fl, d_nop, d_bad, hz;

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) &&
                        (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign in_ready   = !fifo_full && !halted_q;

    assign h_insn = insn_mem[rd_q[AW-1:0]];
    assign h_opc  = h_insn[7:0];
    assign fa     = h_insn[15:8];
    assign fb     = h_insn[23:16];
    assign fc     = h_insn[31:24];

    always_comb begin
        d_op   = '0;
        d_dst  = '0;
        d_src1 = '0;
        d_src2 = '0;
        d_imm  = '0;
        u_dst  = 1'b0;
        u_s1   = 1'b0;
        u_s2   = 1'b0;
        r_fl   = 1'b0;
        w_fl   = 1'b0;
        d_nop  = 1'b0;
        d_bad  = 1'b0;
        case (h_opc)
            8'h00: d_nop = 1'b1;
            8'h10: begin
                d_op  = OP_MOVE;
                d_dst = fa[RW-1:0];
                u_dst = 1'b1;
                d_imm = {{48{h_insn[31]}}, h_insn[31:16]};
            end
            8'h20: begin
                d_op   = OP_ADD;
                d_dst  = fa[RW-1:0];
                d_src1 = fb[RW-1:0];
                d_src2 = fc[RW-1:0];
                u_dst  = 1'b1;
                u_s1   = 1'b1;
                u_s2   = 1'b1;
            end
            8'h21: begin
                d_op   = OP_ADDI;
                d_dst  = fa[RW-1:0];
                d_src1 = fb[RW-1:0];
                u_dst  = 1'b1;
                u_s1   = 1'b1;
                d_imm  = {{56{fc[7]}}, fc};
            end
            8'h30: begin
                d_op   = OP_CMP;
                d_src1 = fa[RW-1:0];
                d_src2 = fb[RW-1:0];
                u_s1   = 1'b1;
                u_s2   = 1'b1;
                w_fl   = 1'b1;
            end
            8'h40: begin
                d_op  = OP_JMP;
                d_imm = {{40{h_insn[31]}}, h_insn[31:8]};
            end
            8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46: begin
                d_op = OP_JCC;
                r_fl = 1'b1;
                // imm carries the flags mask: bit0=EQ, bit1=LT, bit2=GT
                case (h_opc[2:0])
                    3'd1:    d_imm = 64'd1;
                    3'd2:    d_imm = 64'd6;
                    3'd3:    d_imm = 64'd4;
                    3'd4:    d_imm = 64'd2;
                    3'd5:    d_imm = 64'd5;
                    3'd6:    d_imm = 64'd3;
                    default: d_imm = 64'd0;
                endcase
            end
            8'h50: begin
                d_op   = OP_STORE;
                d_src1 = fa[RW-1:0];
                d_src2 = fb[RW-1:0];
                u_s1   = 1'b1;
                u_s2   = 1'b1;
                d_imm  = {56'd0, fc};
            end
            8'h51: begin
                d_op   = OP_LOAD;
                d_dst  = fa[RW-1:0];
                d_src1 = fb[RW-1:0];
                u_dst  = 1'b1;
                u_s1   = 1'b1;
                d_imm  = {{56{fc[7]}}, fc};
            end
            8'hFF: d_op = OP_HALT;
            default: d_bad = 1'b1;
        endcase
    end

    always_comb begin
        for (int i = 0; i < SBN; i++) begin
            wb_mask[i] = wb_valid && (wb_reg == SW'(i));
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    assign busy = sb_q & ~wb_mask;
`else
    assign busy = sb_q;
`endif

    assign hz = (u_dst && busy[SW'(d_dst)]) ||
                (u_s1 && busy[SW'(d_src1)]) ||
                (u_s2 && busy[SW'(d_src2)]) ||
                ((r_fl || w_fl) && busy[FLAGS]);

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        sb_d      = sb_q & ~wb_mask;
        ov_d      = ov_q;
        halted_d  = halted_q;
        illegal_d = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;
        take      = 1'b0;
        push      = in_valid && in_ready && !flush;
        case (state_q)
            S_EMPTY, S_DECODE, S_HAZARD: take = 1'b1;
            S_ISSUE: begin
                if (out_ready) begin
                    ov_d = 1'b0;
                    if (op_q == OP_HALT) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (take) begin
            if (fifo_empty) begin
                state_d = S_EMPTY;
            end else if (d_nop || d_bad) begin
                pop       = 1'b1;
                illegal_d = d_bad;
                state_d   = S_DECODE;
            end else if (hz) begin
                state_d = S_HAZARD;
            end else begin
                pop     = 1'b1;
                load    = 1'b1;
                ov_d    = 1'b1;
                state_d = S_ISSUE;
            end
        end
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (flush) begin
            wr_d      = '0;
            rd_d      = '0;
            ov_d      = 1'b0;
            load      = 1'b0;
            illegal_d = 1'b0;
            state_d   = halted_d ? S_HALTED : S_EMPTY;
        end
        // set after the writeback clear so a same-index set wins
        if (load && u_dst) sb_d[SW'(d_dst)] = 1'b1;
        if (load && w_fl)  sb_d[FLAGS] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q[AW-1:0]]   <= in_pc;
            insn_mem[wr_q[AW-1:0]] <= in_insn;
            mask_mem[wr_q[AW-1:0]] <= in_exec_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_EMPTY;
            wr_q      <= '0;
            rd_q      <= '0;
            sb_q      <= '0;
            ov_q      <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            pc_q      <= '0;
            mask_q    <= '0;
            op_q      <= '0;
            dst_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            imm_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            sb_q      <= sb_d;
            ov_q      <= ov_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            if (load) begin
                pc_q   <= pc_mem[rd_q[AW-1:0]];
                mask_q <= mask_mem[rd_q[AW-1:0]];
                op_q   <= d_op;
                dst_q  <= d_dst;
                src1_q <= d_src1;
                src2_q <= d_src2;
                imm_q  <= d_imm;
            end
        end
    end

    assign out_valid     = ov_q;
    assign out_pc        = pc_q;
    assign out_exec_mask = mask_q;
    assign out_op        = op_q;
    assign out_dst       = dst_q;
    assign out_src1      = src1_q;
    assign out_src2      = src2_q;
    assign out_imm       = imm_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;
endmodule
